// File: rtl/mpc_bus_pkg.sv
// Shared definitions for the MPC accelerator bus master: register map,
// FSM state encoding and bus-address composition.
package mpc_bus_pkg;

  localparam int BUS_AW = 16;

  localparam logic [3:0] REG_STATUS = 4'h0;
  localparam logic [3:0] REG_X      = 4'h1;
  localparam logic [3:0] REG_U      = 4'h2;
  localparam logic [3:0] REG_Q      = 4'h3;
  localparam logic [3:0] REG_R      = 4'h4;
  localparam logic [3:0] REG_X_INIT = 4'h5;
  localparam logic [3:0] REG_X_REF  = 4'h6;
  localparam logic [3:0] REG_U_REF  = 4'h7;
  localparam logic [3:0] REG_X_BND  = 4'h8;
  localparam logic [3:0] REG_U_BND  = 4'h9;

  localparam logic [11:0] OFF_STATUS = 12'h000;
  localparam logic [11:0] OFF_REG_04 = 12'h004;
  localparam logic [11:0] OFF_REG_08 = 12'h008;
  localparam logic [11:0] OFF_REG_10 = 12'h010;
  localparam logic [11:0] OFF_REG_18 = 12'h018;

  localparam logic [BUS_AW-1:0] STATUS_ADDR = {REG_STATUS, OFF_STATUS};

  typedef enum logic [4:0] {
    ST_IDLE, ST_D_FETCH, ST_D_WRITE, ST_D_GAP,
    ST_START_SET, ST_START_GAP, ST_START_CLR, ST_CLR_GAP,
    ST_POLL_RD, ST_POLL_CHK, ST_POLL_GAP,
    ST_TR_PRIME, ST_TR_GAP, ST_TR_FETCH, ST_TR_CAP, ST_OUT,
    ST_FIN, ST_ERR
  } state_t;

  function automatic logic [BUS_AW-1:0] make_addr(input logic [3:0] region,
                                                  input logic [3:0] index,
                                                  input logic [7:0] horizon);
    return {region, index, horizon};
  endfunction

endpackage

// File: rtl/mpc_bus_master_traj_addr_gen.sv
// Walks the x trajectory (horizon-major) then the u trajectory and
// presents the slave address of the current element plus a last flag.
module traj_addr_gen
  import mpc_bus_pkg::*;
#(
  parameter int STATE_DIM = 12,
  parameter int INPUT_DIM = 4,
  parameter int HORIZON   = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [BUS_AW-1:0] addr,
  output logic              last
);

  localparam logic [7:0] X_ELEM_MAX = 8'(STATE_DIM - 1);
  localparam logic [7:0] U_ELEM_MAX = 8'(INPUT_DIM - 1);
  localparam logic [7:0] X_HOR_MAX  = 8'(HORIZON - 1);
  localparam logic [7:0] U_HOR_MAX  = 8'(HORIZON - 2);
  localparam bit         HAS_U      = (HORIZON > 1) && (INPUT_DIM > 0);

  logic       phase_u_q, phase_u_d;
  logic [7:0] elem_q, elem_d;
  logic [7:0] hor_q, hor_d;
  logic [7:0] elem_max, hor_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_u_q <= 1'b0;
      elem_q    <= '0;
      hor_q     <= '0;
    end else begin
      phase_u_q <= phase_u_d;
      elem_q    <= elem_d;
      hor_q     <= hor_d;
    end
  end

  always_comb begin
    elem_max  = phase_u_q ? U_ELEM_MAX : X_ELEM_MAX;
    hor_max   = phase_u_q ? U_HOR_MAX : X_HOR_MAX;
    phase_u_d = phase_u_q;
    elem_d    = elem_q;
    hor_d     = hor_q;
    if (clear) begin
      phase_u_d = 1'b0;
      elem_d    = '0;
      hor_d     = '0;
    end else if (advance) begin
      if (elem_q == elem_max) begin
        elem_d = '0;
        if (hor_q == hor_max) begin
          hor_d     = '0;
          phase_u_d = !phase_u_q && HAS_U;
        end else begin
          hor_d = hor_q + 8'd1;
        end
      end else begin
        elem_d = elem_q + 8'd1;
      end
    end
  end

  // With no u trajectory the final x element is the last word.
  assign addr = make_addr(phase_u_q ? REG_U : REG_X, elem_q[3:0], hor_q);
  assign last = (elem_q == elem_max) && (hor_q == hor_max) && (phase_u_q == HAS_U);

endmodule

// File: rtl/mpc_bus_master.sv
// Avalon-MM initiator: replays configuration descriptors, kicks the MPC
// solver, polls for completion and streams back the x/u trajectories.
module mpc_bus_master
  import mpc_bus_pkg::*;
#(
  parameter int STATE_DIM      = 12,
  parameter int INPUT_DIM      = 4,
  parameter int HORIZON        = 30,
  parameter int ADDR_WIDTH     = 16,
  parameter int EXT_DATA_WIDTH = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int DESC_AW        = 9,
  parameter int POLL_LIMIT     = 65535
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                go,
  input  logic [DESC_AW:0]                    desc_count,
  output logic [DESC_AW-1:0]                  desc_addr,
  input  logic [ADDR_WIDTH+EXT_DATA_WIDTH-1:0] desc_data,
  output logic                                m_chipselect,
  output logic                                m_read,
  output logic                                m_write,
  output logic [ADDR_WIDTH-1:0]               m_addr,
  output logic [EXT_DATA_WIDTH-1:0]           m_writedata,
  input  logic [EXT_DATA_WIDTH-1:0]           m_readdata,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [DATA_WIDTH-1:0]               res_data,
  output logic                                res_last,
  output logic                                busy,
  output logic                                done,
  output logic                                error
);

  localparam int PCW = ($clog2(POLL_LIMIT + 1) > 16) ? $clog2(POLL_LIMIT + 1) : 16;

  state_t                  state_q, state_d;
  logic [DESC_AW:0]        idx_q, idx_d, idx_inc;
  logic [PCW-1:0]          poll_cnt_q, poll_cnt_d, poll_inc;
  logic                    error_q, error_d;
  logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
  logic                    tr_clear, tr_advance, tr_last;
  logic [BUS_AW-1:0]       tr_addr;
  logic                    unused_rd_hi;

  assign unused_rd_hi = ^m_readdata[EXT_DATA_WIDTH-1:DATA_WIDTH];
  assign idx_inc      = idx_q + 1'b1;
  assign poll_inc     = poll_cnt_q + 1'b1;

  traj_addr_gen #(
    .STATE_DIM (STATE_DIM),
    .INPUT_DIM (INPUT_DIM),
    .HORIZON   (HORIZON)
  ) u_traj (
    .clk     (clk),
    .rst     (rst),
    .clear   (tr_clear),
    .advance (tr_advance),
    .addr    (tr_addr),
    .last    (tr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      poll_cnt_q <= '0;
      error_q    <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      error_q    <= error_d;
      res_data_q <= res_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    poll_cnt_d = poll_cnt_q;
    error_d    = error_q;
    res_data_d = res_data_q;
    tr_clear   = 1'b0;
    tr_advance = 1'b0;
    unique case (state_q)
      ST_IDLE: if (go) begin
        error_d    = 1'b0;
        idx_d      = '0;
        poll_cnt_d = '0;
        tr_clear   = 1'b1;
        state_d    = (desc_count == '0) ? ST_START_SET : ST_D_FETCH;
      end
      ST_D_FETCH:   state_d = ST_D_WRITE;
      ST_D_WRITE:   state_d = ST_D_GAP;
      ST_D_GAP: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == desc_count) ? ST_START_SET : ST_D_FETCH;
      end
      ST_START_SET: state_d = ST_START_GAP;
      ST_START_GAP: state_d = ST_START_CLR;
      ST_START_CLR: state_d = ST_CLR_GAP;
      ST_CLR_GAP:   state_d = ST_POLL_RD;
      ST_POLL_RD:   state_d = ST_POLL_CHK;
      ST_POLL_CHK: begin
        if (m_readdata[0]) begin
          state_d = ST_TR_PRIME;
        end else begin
          poll_cnt_d = poll_inc;
          state_d    = (poll_inc == PCW'(POLL_LIMIT)) ? ST_ERR : ST_POLL_GAP;
        end
      end
      ST_POLL_GAP:  state_d = ST_POLL_RD;
      // The slave answers a read with the element latched by the previous
      // read, so each element is read twice and only the second is kept.
      ST_TR_PRIME:  state_d = ST_TR_GAP;
      ST_TR_GAP:    state_d = ST_TR_FETCH;
      ST_TR_FETCH:  state_d = ST_TR_CAP;
      ST_TR_CAP: begin
        res_data_d = m_readdata[DATA_WIDTH-1:0];
        state_d    = ST_OUT;
      end
      ST_OUT: if (res_ready) begin
        tr_advance = 1'b1;
        state_d    = tr_last ? ST_FIN : ST_TR_PRIME;
      end
      ST_FIN:       state_d = ST_IDLE;
      ST_ERR: begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    desc_addr    = '0;
    m_chipselect = 1'b0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_addr       = '0;
    m_writedata  = '0;
    res_valid    = 1'b0;
    res_data     = '0;
    res_last     = 1'b0;
    done         = 1'b0;
    busy         = (state_q != ST_IDLE);
    error        = error_q;
    unique case (state_q)
      ST_D_FETCH: desc_addr = idx_q[DESC_AW-1:0];
      ST_D_WRITE: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_addr       = desc_data[ADDR_WIDTH+EXT_DATA_WIDTH-1 -: ADDR_WIDTH];
        m_writedata  = desc_data[EXT_DATA_WIDTH-1:0];
      end
      ST_START_SET, ST_START_CLR: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_addr       = ADDR_WIDTH'(STATUS_ADDR);
        m_writedata  = {{(EXT_DATA_WIDTH-1){1'b0}}, (state_q == ST_START_SET)};
      end
      ST_POLL_RD: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_addr       = ADDR_WIDTH'(STATUS_ADDR);
      end
      ST_TR_PRIME, ST_TR_FETCH: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
        m_addr       = ADDR_WIDTH'(tr_addr);
      end
      ST_OUT: begin
        res_valid = 1'b1;
        res_data  = res_data_q;
        res_last  = tr_last;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mpc_bus_master.md
Name: mpc_bus_master

Overview:
- Avalon-MM initiator that drives the MPC accelerator's memory-mapped configuration/status slave from the initiator side.
- Replays a descriptor list of (address, data) writes: A, B, Q, R, x_init, x_ref, u_ref, bounds, tolerances and rho.
- Pulses the start register, polls the status register until the solver reports done, then reads back the full x and u trajectories.
- Streams the trajectory words out on a valid/ready interface for the host-side or logging path.

Parameters:
- STATE_DIM, 12, state dimension nx
- INPUT_DIM, 4, input dimension nu
- HORIZON, 30, horizon N; x has N steps, u has N-1 steps
- ADDR_WIDTH, 16, bus address width
- EXT_DATA_WIDTH, 32, bus data width
- DATA_WIDTH, 16, trajectory word width (Q8.8)
- DESC_AW, 9, descriptor RAM address width
- POLL_LIMIT, 65535, maximum status polls before timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- go  in  1  start sequence; sampled only in IDLE
- desc_count  in  DESC_AW+1  number of descriptors to replay
- desc_addr  out  DESC_AW  descriptor RAM read address
- desc_data  in  ADDR_WIDTH+EXT_DATA_WIDTH  {bus addr, bus data}; valid 1 cycle after desc_addr
- m_chipselect  out  1  bus select
- m_read  out  1  read strobe
- m_write  out  1  write strobe
- m_addr  out  ADDR_WIDTH  bus address
- m_writedata  out  EXT_DATA_WIDTH  write data
- m_readdata  in  EXT_DATA_WIDTH  read data, registered by slave; valid the cycle after m_read
- res_valid  out  1  result word valid
- res_ready  in  1  consumer ready
- res_data  out  DATA_WIDTH  trajectory word
- res_last  out  1  final word of the sequence
- busy  out  1  high in any state other than IDLE
- done  out  1  1-cycle pulse on successful completion
- error  out  1  poll timeout; sticky until next accepted go

Behaviour:
- Reset values: every output 0, FSM in IDLE, all counters 0.
- Reset asserted mid-sequence aborts immediately: no further bus strobes are issued.
- Bus rules:
  - Every strobe lasts exactly 1 cycle, with m_chipselect high in that cycle.
  - Every strobe is followed by at least 1 idle cycle (chipselect low).
  - m_read and m_write are never high together.
- States and transitions:
  - IDLE: on go, clear error. If desc_count==0, go to START_SET; otherwise go to D_FETCH.
  - D_FETCH: drive desc_addr=idx, then go to D_WRITE.
  - D_WRITE: write m_addr=desc_data[top ADDR_WIDTH bits], m_writedata=desc_data[low EXT_DATA_WIDTH bits].
  - D_GAP: idle cycle. idx++; if idx==desc_count go to START_SET, else go to D_FETCH. Each descriptor therefore costs 3 cycles.
  - START_SET: write addr 0x0000, data 1. Then a gap cycle.
  - START_CLR: write addr 0x0000, data 0, so the slave's start_solving latch is released. Then a gap cycle.
  - POLL_RD: read addr 0x0000.
  - POLL_CHK: capture m_readdata[0].
    - If 1, go to TR_PRIME.
    - If 0, poll_cnt++. If poll_cnt==POLL_LIMIT go to ERR; otherwise return to POLL_RD via a gap cycle.
  - TR_PRIME: read the element address. This latches the slave's memory read address; the returned data is discarded.
  - TR_GAP: 1 idle cycle.
  - TR_FETCH: read the same address again.
  - TR_CAP: load res_data=m_readdata[DATA_WIDTH-1:0], assert res_valid, go to OUT.
  - OUT: hold res_data, res_valid and res_last until res_ready. The bus stays idle during backpressure. On handshake, advance the element and go to TR_PRIME, or to FIN after the last element.
  - FIN: pulse done, return to IDLE.
  - ERR: set error, return to IDLE. done is not pulsed.
- Element order:
  - x first: h outer 0..HORIZON-1, state s inner 0..STATE_DIM-1, addr = 0x1000 | s<<8 | h.
  - Then u: h 0..HORIZON-2, input i 0..INPUT_DIM-1, addr = 0x2000 | i<<8 | h.
  - Total words = STATE_DIM*HORIZON + INPUT_DIM*(HORIZON-1) = 476 at default parameters.
  - res_last is high only with the 476th word.
- Counters:
  - idx is DESC_AW+1 bits.
  - poll_cnt is 16 bits minimum, enough to reach POLL_LIMIT.
  - Element counters wrap to 0 at their dimension limit; the horizon counter advances on wrap.
- go while busy is ignored. go held high in IDLE after FIN restarts the sequence the next cycle.

Decomposition:
- Shared package mpc_bus_pkg:
  - register-region nibbles: 0x0 status, 0x1 x/A, 0x2 u/B, 0x3 Q, 0x4 R, 0x5 x_init, 0x6 x_ref, 0x7 u_ref, 0x8 x bounds, 0x9 u bounds
  - status offsets: 0x000 status/start, 0x004, 0x008, 0x010, 0x018
  - FSM state enum typedef
  - a function composing {region, index<<8, horizon} into a bus address
- Sub-module traj_addr_gen: x/u index and horizon counters, address output, last flag, advance input.

Test Plan:
- desc_count=3 with entries (0x1000, 0x0100), (0x8080, 0x7FFF), (0x0018, 0x0080) -> three 1-cycle writes with exactly those addr/data values, each separated by 2 non-strobe cycles; then writes 0x0000=1 and 0x0000=0.
- desc_count=0 -> the first bus strobe after go is the write 0x0000=1.
- Slave model reports done on the 5th poll -> exactly 5 reads of 0x0000, then the first trajectory strobe is a prime read of 0x1000.
- Status never done, POLL_LIMIT=8 -> 8 polls, then error=1, busy=0, done stays 0; the next go clears error.
- Slave model returns value = address with 1-read lag; res_ready low for 4 cycles on word 2 -> 476 words in x-then-u order with correct values, res_data stable during the stall, res_last only on the word for addr 0x231C, then a single done pulse.
- rst asserted during the trajectory phase -> all outputs 0 asynchronously; after release, no strobes occur until the next go.
